// File: rtl/a0_uart_tx.sv
// rtl/a0_uart_tx.sv - a0 change-capture word FIFO feeding an 8N1 UART transmitter
// Each new a0 value is queued and sent as four bytes, least-significant byte first.

module a0_uart_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign level   = wptr - rptr;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end
endmodule

module a0_uart_tx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [31:0]                   a0,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [1:0]    byte_idx, byte_idx_nx;
  logic [31:0]   word, word_nx;
  logic [31:0]   a0_q;
  logic [31:0]   head;
  logic          push;
  logic          pop;
  logic          empty;
  logic          drop;
  logic          bit_end;

  assign push = (a0 != a0_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a0_q     <= '0;
      overflow <= 1'b0;
    end else begin
      a0_q <= a0;
      if (drop) overflow <= 1'b1;
    end
  end

  a0_uart_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (a0),
    .pop   (pop),
    .rdata (head),
    .empty (empty),
    .drop  (drop),
    .level (level)
  );

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = (state != IDLE) || (level != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      word     <= '0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      bit_idx  <= bit_idx_nx;
      byte_idx <= byte_idx_nx;
      word     <= word_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    byte_idx_nx = byte_idx;
    word_nx     = word;
    pop         = 1'b0;
    tx          = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          word_nx     = head;
          byte_idx_nx = 2'd0;
          cnt_nx      = '0;
          state_nx    = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (bit_end) begin
          cnt_nx     = '0;
          bit_idx_nx = 3'd0;
          state_nx   = DATA;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      DATA: begin
        // {byte_idx, bit_idx} is the bit position 8*byte + bit within the word.
        tx = word[{byte_idx, bit_idx}];
        if (bit_end) begin
          cnt_nx = '0;
          if (bit_idx == 3'd7) state_nx = STOP;
          else bit_idx_nx = bit_idx + 3'd1;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (byte_idx != 2'd3) begin
            byte_idx_nx = byte_idx + 2'd1;
            state_nx    = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
